// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter for a small register bank shared by requesters A and B.
// Optional early read forwarding is enabled by defining RD_BYPASS_EN.
module reg_bank_write_arbiter #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  data_b,
  output logic              gnt_b,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_b_q, last_b_d;  // 1: B won the most recent arbitration
  logic   win_a, win_b;
  logic [WIDTH-1:0] bank [DEPTH];

  // Only IDLE arbitrates; on contention the requester that did not win last time goes.
  always_comb begin
    win_a = (state_q == IDLE) && req_a && (!req_b || last_b_q);
    win_b = (state_q == IDLE) && req_b && (!req_a || !last_b_q);
  end

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        if (win_a) begin
          state_d  = GRANT_A;
          last_b_d = 1'b0;
        end else if (win_b) begin
          state_d  = GRANT_B;
          last_b_d = 1'b1;
        end
      end
      GRANT_A, GRANT_B: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(negedge clock) begin
    if (clear) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      logic [WIDTH-1:0] cell_q;

      always_ff @(negedge clock) begin
        if (clear) begin
          cell_q <= '0;
        end else if (win_a && (addr_a == ADDR_W'(gi))) begin
          cell_q <= data_a;
        end else if (win_b && (addr_b == ADDR_W'(gi))) begin
          cell_q <= data_b;
        end
      end

      assign bank[gi] = cell_q;
    end
  endgenerate

  assign gnt_a = (state_q == GRANT_A);
  assign gnt_b = (state_q == GRANT_B);
  assign busy  = (state_q != IDLE);

`ifdef RD_BYPASS_EN
  // Forward the data about to be committed so readers see it one cycle early.
  always_comb begin
    rd_data = bank[rd_addr];
    if (win_a && (addr_a == rd_addr)) begin
      rd_data = data_a;
    end else if (win_b && (addr_b == rd_addr)) begin
      rd_data = data_b;
    end
  end
`else
  assign rd_data = bank[rd_addr];
`endif

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter: directed scenarios followed by random
// protocol-respecting traffic, all checked against a transaction-level model.
module tb_reg_bank_write_arbiter;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [1:0] addr_a = '0, addr_b = '0, rd_addr = '0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       gnt_a, gnt_b, busy;
  logic [7:0] rd_data;

  int total = 0;
  int bad   = 0;

  // Model: bank contents, who won last, and who is being granted this cycle (0 none, 1 A, 2 B).
  logic [7:0] m_bank [4];
  bit         m_last_b = 1'b1;
  int         m_gnt    = 0;
  logic [7:0] rd_pre_seen;

  reg_bank_write_arbiter #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut (
    .clock  (clock),
    .clear  (clear),
    .req_a  (req_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .gnt_a  (gnt_a),
    .req_b  (req_b),
    .addr_b (addr_b),
    .data_b (data_b),
    .gnt_b  (gnt_b),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, check the combinational read before
  // the falling edge, advance the model at the edge, then check registered outputs.
  task automatic cycle(input bit c, input bit ra, input logic [1:0] aa, input logic [7:0] da,
                       input bit rb, input logic [1:0] ab, input logic [7:0] db,
                       input logic [1:0] ra_rd);
    int w;
    logic [7:0] exp_rd;
    @(posedge clock);
    clear = c; req_a = ra; addr_a = aa; data_a = da;
    req_b = rb; addr_b = ab; data_b = db; rd_addr = ra_rd;
    #1;
    w = 0;
    if (m_gnt == 0) begin
      if (ra && rb) w = m_last_b ? 1 : 2;
      else if (ra)  w = 1;
      else if (rb)  w = 2;
    end
    exp_rd = m_bank[ra_rd];
`ifdef RD_BYPASS_EN
    if (w == 1 && aa == ra_rd) exp_rd = da;
    else if (w == 2 && ab == ra_rd) exp_rd = db;
`endif
    rd_pre_seen = rd_data;
    check_eq("rd_pre", rd_data, exp_rd);
    @(negedge clock);
    if (c) begin
      for (int i = 0; i < 4; i++) m_bank[i] = '0;
      m_gnt = 0;
      m_last_b = 1'b1;
    end else begin
      m_gnt = w;
      if (w == 1) begin m_bank[aa] = da; m_last_b = 1'b0; end
      if (w == 2) begin m_bank[ab] = db; m_last_b = 1'b1; end
    end
    #1;
    check_eq("gnt_a", gnt_a, (m_gnt == 1));
    check_eq("gnt_b", gnt_b, (m_gnt == 2));
    check_eq("busy", busy, (m_gnt != 0));
    check_eq("rd_post", rd_data, m_bank[ra_rd]);
    $display("cyc clr=%0b ra=%0b/%0d/%02h rb=%0b/%0d/%02h rd[%0d]=%02h gnt=%0b%0b busy=%0b",
             c, ra, aa, da, rb, ab, db, ra_rd, rd_data, gnt_a, gnt_b, busy);
  endtask

  initial begin
    bit         ra, rb;
    logic [1:0] aa, ab;
    logic [7:0] da, db;

    for (int i = 0; i < 4; i++) m_bank[i] = 8'hXX;

    // Reset for two edges, then every register reads zero.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 2'(i));
      check_eq("t1_zero", rd_data, 8'h00);
    end

    // Single write from A.
    cycle(0, 1, 2, 8'hA5, 0, 0, 0, 2);
    check_eq("t2_gnt_a", gnt_a, 1);
    check_eq("t2_rd", rd_data, 8'hA5);
    cycle(0, 0, 0, 0, 0, 0, 0, 2);
    check_eq("t2_busy_off", busy, 0);

    // Contention from reset: A first, B two edges later.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 8'h11, 1, 3, 8'h33, 1);
    check_eq("t3_first_a", gnt_a, 1);
    cycle(0, 0, 0, 0, 1, 3, 8'h33, 3);
    check_eq("t3_gap", gnt_b, 0);
    cycle(0, 0, 0, 0, 1, 3, 8'h33, 3);
    check_eq("t3_then_b", gnt_b, 1);
    check_eq("t3_bank3", rd_data, 8'h33);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("t3_bank1", rd_data, 8'h11);

    // Both held continuously: A, idle, B, idle, ...
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 0, 8'(8'h40 + k), 1, 0, 8'(8'h80 + k), 0);
      check_eq("t4_alt_a", gnt_a, (k % 4 == 0));
      check_eq("t4_alt_b", gnt_b, (k % 4 == 2));
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Clear during GRANT_B wipes the write just committed.
    cycle(0, 0, 0, 0, 1, 0, 8'h7E, 0);
    check_eq("t5_gnt_b", gnt_b, 1);
    cycle(1, 0, 0, 0, 1, 0, 8'h7E, 0);
    check_eq("t5_gnt_off", gnt_b, 0);
    check_eq("t5_idle", busy, 0);
    check_eq("t5_bank0", rd_data, 8'h00);

    // Early forwarding of a winning write to the read port.
    cycle(0, 1, 1, 8'h55, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1, 8'hC3, 1);
`ifdef RD_BYPASS_EN
    check_eq("t6_fwd", rd_pre_seen, 8'hC3);
`else
    check_eq("t6_nofwd", rd_pre_seen, 8'h55);
`endif
    check_eq("t6_after", rd_data, 8'hC3);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);

    // Random traffic; each requester holds its request until granted.
    ra = 0; rb = 0; aa = 0; ab = 0; da = 0; db = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ra || m_gnt == 1) begin
        ra = ($urandom_range(0, 2) != 0);
        aa = 2'($urandom_range(0, 3));
        da = 8'($urandom);
      end
      if (!rb || m_gnt == 2) begin
        rb = ($urandom_range(0, 2) != 0);
        ab = 2'($urandom_range(0, 3));
        db = 8'($urandom);
      end
      cycle(($urandom_range(0, 39) == 0), ra, aa, da, rb, ab, db, 2'($urandom_range(0, 3)));
      check_eq("excl", gnt_a & gnt_b, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
